// File: rtl/connect4_move_ctrl.sv
// connect4_move_ctrl
//
// Turns single-cycle player-input pulses into Connect-4 moves. Owns the cursor
// column, the side to move and both occupancy maps. A put scans the cursor
// column bottom-up, one row per cycle. When it finds the first empty cell, the
// piece is committed and an external win checker gets a fixed window of
// CHECK_CYCLES cycles to raise win_detected.
//
// Ports
//   clk           system clock
//   rst           asynchronous active-low reset
//   left_pulse    one-cycle request: cursor left (saturates at 0)
//   right_pulse   one-cycle request: cursor right (saturates at COLS-1)
//   put_pulse     one-cycle request: drop a piece in the cursor column
//   new_game      synchronous clear, highest priority in every state
//   win_detected  from external checker, sampled only while checking
//   cursor_col    current cursor column
//   player        side to move (0 = red, 1 = yellow)
//   board_red     red occupancy, bit index = row*COLS + col, row 0 at bottom
//   board_yel     yellow occupancy, same indexing
//   last_row      row of the last committed piece
//   last_col      column of the last committed piece
//   move_done     one-cycle pulse when a piece is committed
//   col_full      one-cycle pulse when a put hits a full column
//   busy          high while dropping or checking
//   game_over     high once the game has ended
//   winner        0 none, 1 red, 2 yellow, 3 draw
module connect4_move_ctrl #(
  parameter int ROWS         = 6,
  parameter int COLS         = 7,
  parameter int CHECK_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      left_pulse,
  input  logic                      right_pulse,
  input  logic                      put_pulse,
  input  logic                      new_game,
  input  logic                      win_detected,
  output logic [$clog2(COLS)-1:0]   cursor_col,
  output logic                      player,
  output logic [ROWS*COLS-1:0]      board_red,
  output logic [ROWS*COLS-1:0]      board_yel,
  output logic [$clog2(ROWS)-1:0]   last_row,
  output logic [$clog2(COLS)-1:0]   last_col,
  output logic                      move_done,
  output logic                      col_full,
  output logic                      busy,
  output logic                      game_over,
  output logic [1:0]                winner
);

  localparam int CUR_W  = $clog2(COLS);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int CELLS  = ROWS * COLS;
  localparam int CELL_W = $clog2(CELLS);
  localparam int MC_W   = $clog2(CELLS + 1);
  localparam int CNT_W  = $clog2(CHECK_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DROP, CHECK, OVER} state_t;

  state_t             state_q, state_d;
  logic [CUR_W-1:0]   cursor_q, cursor_d;
  logic               player_q, player_d;
  logic [CELLS-1:0]   red_q, red_d;
  logic [CELLS-1:0]   yel_q, yel_d;
  logic [ROW_W-1:0]   last_row_q, last_row_d;
  logic [CUR_W-1:0]   last_col_q, last_col_d;
  logic               move_done_q, move_done_d;
  logic               col_full_q, col_full_d;
  logic               busy_q, busy_d;
  logic               over_q, over_d;
  logic [1:0]         winner_q, winner_d;
  logic [ROW_W-1:0]   row_q, row_d;       // row being probed during DROP
  logic [CUR_W-1:0]   col_q, col_d;       // column latched at put time
  logic [MC_W-1:0]    mcount_q, mcount_d; // committed pieces, reaches CELLS at most
  logic [CNT_W-1:0]   cnt_q, cnt_d;       // remaining win-check cycles

  logic [CELL_W-1:0]  cell_idx;
  logic               cell_occupied;

  assign cell_idx      = CELL_W'(row_q) * CELL_W'(COLS) + CELL_W'(col_q);
  assign cell_occupied = red_q[cell_idx] | yel_q[cell_idx];

  // Next-state logic. Every register has a _d twin computed here.
  always_comb begin
    // NOTE: every _d gets a default before any branch so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    cursor_d    = cursor_q;
    player_d    = player_q;
    red_d       = red_q;
    yel_d       = yel_q;
    last_row_d  = last_row_q;
    last_col_d  = last_col_q;
    row_d       = row_q;
    col_d       = col_q;
    mcount_d    = mcount_q;
    cnt_d       = cnt_q;
    winner_d    = winner_q;
    move_done_d = 1'b0;
    col_full_d  = 1'b0;

    if (new_game) begin
      state_d    = IDLE;
      cursor_d   = CUR_W'(COLS / 2);
      player_d   = 1'b0;
      red_d      = '0;
      yel_d      = '0;
      last_row_d = '0;
      last_col_d = '0;
      row_d      = '0;
      col_d      = '0;
      mcount_d   = '0;
      cnt_d      = '0;
      winner_d   = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          // A put wins over cursor motion in the same cycle.
          if (put_pulse) begin
            state_d = DROP;
            row_d   = '0;
            col_d   = cursor_q;
          end else if (left_pulse && !right_pulse) begin
            if (cursor_q != '0) cursor_d = cursor_q - CUR_W'(1);
          end else if (right_pulse && !left_pulse) begin
            if (cursor_q != CUR_W'(COLS - 1)) cursor_d = cursor_q + CUR_W'(1);
          end
        end

        DROP: begin
          if (!cell_occupied) begin
            if (player_q) yel_d[cell_idx] = 1'b1;
            else          red_d[cell_idx] = 1'b1;
            last_row_d  = row_q;
            last_col_d  = col_q;
            move_done_d = 1'b1;
            mcount_d    = mcount_q + MC_W'(1);
            cnt_d       = CNT_W'(CHECK_CYCLES);
            state_d     = CHECK;
          end else if (row_q != ROW_W'(ROWS - 1)) begin
            row_d = row_q + ROW_W'(1);
          end else begin
            col_full_d = 1'b1;
            state_d    = IDLE;
          end
        end

        CHECK: begin
          if (win_detected) begin
            // The mover wins; player stays on the winning side.
            winner_d = player_q ? 2'd2 : 2'd1;
            state_d  = OVER;
          end else if (cnt_q <= CNT_W'(1)) begin
            player_d = ~player_q;
            if (mcount_q == MC_W'(CELLS)) begin
              winner_d = 2'd3;
              state_d  = OVER;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        OVER: ;

        default: state_d = IDLE;
      endcase
    end

    // Status flags are registered from the next state so they line up with it.
    busy_d = (state_d == DROP) || (state_d == CHECK);
    over_d = (state_d == OVER);
  end

  // NOTE: the board maps are ordinary flops and are cleared by reset like all
  // other state, so a move aborted by reset never leaves a visible bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cursor_q    <= CUR_W'(COLS / 2);
      player_q    <= 1'b0;
      red_q       <= '0;
      yel_q       <= '0;
      last_row_q  <= '0;
      last_col_q  <= '0;
      move_done_q <= 1'b0;
      col_full_q  <= 1'b0;
      busy_q      <= 1'b0;
      over_q      <= 1'b0;
      winner_q    <= 2'd0;
      row_q       <= '0;
      col_q       <= '0;
      mcount_q    <= '0;
      cnt_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      player_q    <= player_d;
      red_q       <= red_d;
      yel_q       <= yel_d;
      last_row_q  <= last_row_d;
      last_col_q  <= last_col_d;
      move_done_q <= move_done_d;
      col_full_q  <= col_full_d;
      busy_q      <= busy_d;
      over_q      <= over_d;
      winner_q    <= winner_d;
      row_q       <= row_d;
      col_q       <= col_d;
      mcount_q    <= mcount_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cursor_col = cursor_q;
  assign player     = player_q;
  assign board_red  = red_q;
  assign board_yel  = yel_q;
  assign last_row   = last_row_q;
  assign last_col   = last_col_q;
  assign move_done  = move_done_q;
  assign col_full   = col_full_q;
  assign busy       = busy_q;
  assign game_over  = over_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_connect4_move_ctrl.sv
// Self-checking bench for connect4_move_ctrl. A game-level model (grid of
// owners, column heights, move count) predicts each commit/reject event; the
// expectation is queued when the put is issued, and a monitor pops and checks
// it when move_done or col_full appears.
module tb_connect4_move_ctrl;

  localparam int ROWS  = 6;
  localparam int COLS  = 7;
  localparam int CHK   = 2;
  localparam int CELLS = ROWS * COLS;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic left_pulse = 1'b0, right_pulse = 1'b0, put_pulse = 1'b0;
  logic new_game = 1'b0, win_detected = 1'b0;
  logic [2:0]       cursor_col;
  logic             player;
  logic [CELLS-1:0] board_red, board_yel;
  logic [2:0]       last_row, last_col;
  logic             move_done, col_full, busy, game_over;
  logic [1:0]       winner;

  connect4_move_ctrl #(.ROWS(ROWS), .COLS(COLS), .CHECK_CYCLES(CHK)) dut (
    .clk(clk), .rst(rst),
    .left_pulse(left_pulse), .right_pulse(right_pulse), .put_pulse(put_pulse),
    .new_game(new_game), .win_detected(win_detected),
    .cursor_col(cursor_col), .player(player),
    .board_red(board_red), .board_yel(board_yel),
    .last_row(last_row), .last_col(last_col),
    .move_done(move_done), .col_full(col_full),
    .busy(busy), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string name, logic [63:0] actual, logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // ---------------- reference model ----------------
  int grid [ROWS][COLS];   // 0 empty, 1 red, 2 yellow
  int m_cursor, m_player, m_count, m_winner;
  bit m_over;

  typedef struct {
    bit               full;
    int               row;
    int               col;
    logic [CELLS-1:0] red;
    logic [CELLS-1:0] yel;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [CELLS-1:0] board_of(int who);
    logic [CELLS-1:0] b = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (grid[r][c] == who) b[r*COLS + c] = 1'b1;
    return b;
  endfunction

  function automatic int height(int c);
    for (int r = 0; r < ROWS; r++)
      if (grid[r][c] == 0) return r;
    return ROWS;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) grid[r][c] = 0;
    m_cursor = COLS / 2;
    m_player = 0;
    m_count  = 0;
    m_winner = 0;
    m_over   = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_state(string tag);
    check({tag, "_cursor"}, cursor_col, m_cursor);
    check({tag, "_player"}, player, m_player);
    check({tag, "_red"}, board_red, board_of(1));
    check({tag, "_yel"}, board_yel, board_of(2));
    check({tag, "_winner"}, winner, m_winner);
    check({tag, "_over"}, game_over, m_over);
    check({tag, "_busy"}, busy, 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst && (move_done || col_full)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", col_full, e.full);
        check("event_single", move_done & col_full, 0);
        if (!e.full) begin
          check("last_row", last_row, e.row);
          check("last_col", last_col, e.col);
        end
        check("event_red", board_red, e.red);
        check("event_yel", board_yel, e.yel);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_lr(bit l, bit r);
    @(negedge clk);
    left_pulse   = l;
    right_pulse  = r;
    win_detected = ($urandom_range(0, 3) == 0);   // must be ignored outside CHECK
    @(negedge clk);
    left_pulse   = 1'b0;
    right_pulse  = 1'b0;
    win_detected = 1'b0;
    if (!m_over) begin
      if (l && !r && m_cursor > 0)        m_cursor--;
      if (r && !l && m_cursor < COLS - 1) m_cursor++;
    end
    check("cursor_move", cursor_col, m_cursor);
  endtask

  task automatic goto_col(int c);
    while (m_cursor < c) pulse_lr(0, 1);
    while (m_cursor > c) pulse_lr(1, 0);
  endtask

  // win_k: 0 = no win; 1..CHK raise win_detected in that CHECK cycle;
  // CHK+1 raises it one cycle after the window closes (must be ignored).
  task automatic do_put(bit with_left, int win_k, bit noise);
    int   col, row, cyc, n;
    bit   full, got;
    exp_t e;
    col  = m_cursor;
    row  = height(col);
    full = (row == ROWS);
    if (!full) begin
      grid[row][col] = m_player + 1;
      m_count++;
    end
    e.full = full;
    e.row  = full ? 0 : row;
    e.col  = col;
    e.red  = board_of(1);
    e.yel  = board_of(2);
    exp_q.push_back(e);

    @(negedge clk);
    put_pulse  = 1'b1;
    left_pulse = with_left;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        put_pulse  = noise;   // a put while busy must be dropped
        left_pulse = 1'b0;
        right_pulse = noise;
      end else if (cyc == 2) begin
        put_pulse   = 1'b0;
        right_pulse = 1'b0;
      end
      if (move_done || col_full) got = 1'b1;
    end
    put_pulse = 1'b0; right_pulse = 1'b0;
    check("put_latency", cyc, full ? ROWS + 1 : row + 2);

    if (got && !full && win_k >= 1) begin
      repeat (win_k - 1) @(negedge clk);
      win_detected = 1'b1;
      @(negedge clk);
      win_detected = 1'b0;
    end

    if (!full) begin
      if (win_k >= 1 && win_k <= CHK) begin
        m_winner = m_player + 1;
        m_over   = 1'b1;
      end else begin
        m_player ^= 1;
        if (m_count == CELLS) begin
          m_winner = 3;
          m_over   = 1'b1;
        end
      end
    end

    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_state("after_put");
  endtask

  task automatic over_noise();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      left_pulse   = (i == 0);
      right_pulse  = (i == 1);
      put_pulse    = (i >= 2);
      win_detected = (i == 3);
    end
    @(negedge clk);
    left_pulse = 1'b0; right_pulse = 1'b0; put_pulse = 1'b0; win_detected = 1'b0;
    repeat (3) @(negedge clk);
    check_state("over_hold");
  endtask

  task automatic start_new_game();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    model_reset();
    check_state("new_game");
    check("new_game_last_row", last_row, 0);
    check("new_game_last_col", last_col, 0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check_state("reset");
    check("reset_last_row", last_row, 0);
    check("reset_last_col", last_col, 0);
    check("reset_move_done", move_done, 0);

    // Cursor saturation both ways, and left+right together.
    repeat (3) pulse_lr(1, 0);
    pulse_lr(1, 0);
    repeat (7) pulse_lr(0, 1);
    pulse_lr(1, 1);

    // Two stacked pieces in column 3 (red bit 3, then yellow bit 10).
    goto_col(3);
    do_put(0, 0, 0);
    do_put(0, 0, 0);

    // Fill column 0, then one more put is rejected.
    goto_col(0);
    repeat (ROWS) do_put(0, 0, 0);
    do_put(0, 0, 0);

    // left+put together drops in the original column; puts while busy dropped.
    goto_col(2);
    do_put(1, 0, 1);
    do_put(0, CHK + 1, 1);   // late win_detected is ignored

    // Red wins in the 2nd CHECK cycle.
    start_new_game();
    do_put(0, 2, 0);
    over_noise();
    start_new_game();

    // Fill the whole board with no win: draw.
    for (int c = 0; c < COLS; c++) begin
      goto_col(c);
      repeat (ROWS) do_put(0, 0, 0);
    end
    check("draw_winner", winner, 3);
    over_noise();
    start_new_game();

    // Reset in the middle of a drop aborts it.
    repeat (2) do_put(0, 0, 0);
    @(negedge clk);
    put_pulse = 1'b1;
    @(negedge clk);
    put_pulse = 1'b0;
    #1 rst = 1'b0;
    #1;
    model_reset();
    check("rst_busy", busy, 0);
    check("rst_red", board_red, 0);
    check("rst_yel", board_yel, 0);
    check("rst_cursor", cursor_col, COLS / 2);
    check("rst_last_row", last_row, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check_state("after_rst");

    // Randomized games.
    for (int g = 0; g < 4; g++) begin
      int moves;
      start_new_game();
      moves = 0;
      while (!m_over && moves < 70) begin
        if ($urandom_range(0, 2) == 0) begin
          pulse_lr($urandom_range(0, 1), $urandom_range(0, 1));
        end else begin
          do_put($urandom_range(0, 3) == 0,
                 ($urandom_range(0, 19) == 0) ? $urandom_range(1, CHK + 1) : 0,
                 $urandom_range(0, 3) == 0);
          moves++;
        end
      end
      if (m_over) over_noise();
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
